// File: rtl/axis_stream_monitor.sv
// AXI4-Stream passthrough monitor: zero-latency wire-through plus beat/byte/packet
// statistics and a first-word-fall-through FIFO holding the last packet lengths.
// Optional macro AXIS_MON_STALL_EN enables the stall_count counter (else stall_count = 0).
// Ports:
//   clk, reset (sync, active high), clear (sync clear pulse, same effect as reset)
//   input_s_axis_* / output_m_axis_* : upstream / downstream stream, combinational path
//   byte_count, beat_count, tlast_count        : wrapping totals
//   last_pkt_bytes, max_pkt_bytes, min_pkt_bytes : packet length statistics
//   stall_count, hist_drop_count               : saturating event counters
//   in_packet                                  : high between a first and a tlast beat
//   hist_rd_en, hist_rd_data, hist_empty, hist_full : packet length history FIFO
module axis_stream_monitor #(
   parameter int C_AXIS_BYTEWIDTH = 4,
   parameter int C_COUNT_WIDTH    = 32,
   parameter int C_HIST_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          input_s_axis_tvalid,
   input  logic [C_AXIS_BYTEWIDTH*8-1:0] input_s_axis_tdata,
   input  logic [C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tstrb,
   input  logic                          input_s_axis_tlast,
   output logic                          input_s_axis_tready,
   output logic                          output_m_axis_tvalid,
   output logic [C_AXIS_BYTEWIDTH*8-1:0] output_m_axis_tdata,
   output logic [C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tstrb,
   output logic                          output_m_axis_tlast,
   input  logic                          output_m_axis_tready,
   output logic [C_COUNT_WIDTH-1:0]      byte_count,
   output logic [C_COUNT_WIDTH-1:0]      beat_count,
   output logic [C_COUNT_WIDTH-1:0]      tlast_count,
   output logic [C_COUNT_WIDTH-1:0]      last_pkt_bytes,
   output logic [C_COUNT_WIDTH-1:0]      max_pkt_bytes,
   output logic [C_COUNT_WIDTH-1:0]      min_pkt_bytes,
   output logic [C_COUNT_WIDTH-1:0]      stall_count,
   output logic [C_COUNT_WIDTH-1:0]      hist_drop_count,
   output logic                          in_packet,
   input  logic                          hist_rd_en,
   output logic [C_COUNT_WIDTH-1:0]      hist_rd_data,
   output logic                          hist_empty,
   output logic                          hist_full
);

   localparam int BW = C_AXIS_BYTEWIDTH;
   localparam int CW = C_COUNT_WIDTH;
   localparam int HD = C_HIST_DEPTH;
   localparam int AW = $clog2(HD);

   typedef enum logic {
      S_IDLE,
      S_IN_PKT
   } state_t;

   function automatic logic [CW-1:0] popcnt(input logic [BW-1:0] s);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < BW; i++) begin
         c = c + CW'(s[i]);
      end
      return c;
   endfunction

   // clear behaves exactly like reset
   logic rst;
   assign rst = reset | clear;

   assign output_m_axis_tvalid = input_s_axis_tvalid;
   assign output_m_axis_tdata  = input_s_axis_tdata;
   assign output_m_axis_tstrb  = input_s_axis_tstrb;
   assign output_m_axis_tlast  = input_s_axis_tlast;
   assign input_s_axis_tready  = output_m_axis_tready;

   state_t          state_q, state_d;
   logic [CW-1:0]   byte_q, byte_d;
   logic [CW-1:0]   beat_q, beat_d;
   logic [CW-1:0]   tlast_q, tlast_d;
   logic [CW-1:0]   last_q, last_d;
   logic [CW-1:0]   max_q, max_d;
   logic [CW-1:0]   min_q, min_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [CW-1:0]   mem_q [HD];

   logic            beat;
   logic [CW-1:0]   pc;
   logic [CW:0]     sum;
   logic [CW-1:0]   len;
   logic            push;
   logic            pop_ok;
   logic            push_ok;
   logic            full;
   logic            empty;

   assign beat  = input_s_axis_tvalid & output_m_axis_tready & ~rst;
   assign pc    = popcnt(input_s_axis_tstrb);
   assign sum   = {1'b0, acc_q} + {1'b0, pc};
   // saturating packet length: carry out pins the result at all-ones
   assign len   = sum[CW] ? '1 : sum[CW-1:0];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(HD));
   assign push  = beat & input_s_axis_tlast;
   assign pop_ok  = hist_rd_en & ~empty & ~rst;
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      beat_d   = beat_q;
      tlast_d  = tlast_q;
      last_d   = last_q;
      max_d    = max_q;
      min_d    = min_q;
      acc_d    = acc_q;
      drop_d   = drop_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      if (beat) begin
         byte_d = byte_q + pc;
         beat_d = beat_q + 1'b1;
         if (input_s_axis_tlast) begin
            tlast_d = tlast_q + 1'b1;
            last_d  = len;
            acc_d   = '0;
            state_d = S_IDLE;
            if (len > max_q) max_d = len;
            if (len < min_q) min_d = len;
         end else begin
            acc_d   = len;
            state_d = S_IN_PKT;
         end
      end

      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push && !push_ok && drop_q != '1) begin
         drop_d = drop_q + 1'b1;
      end

      if (rst) begin
         state_d  = S_IDLE;
         byte_d   = '0;
         beat_d   = '0;
         tlast_d  = '0;
         last_d   = '0;
         max_d    = '0;
         min_d    = '1;
         acc_d    = '0;
         drop_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      beat_q   <= beat_d;
      tlast_q  <= tlast_d;
      last_q   <= last_d;
      max_q    <= max_d;
      min_q    <= min_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
   end

   // storage needs no reset: the head is masked to 0 while empty
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= len;
   end

`ifdef AXIS_MON_STALL_EN
   logic [CW-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (input_s_axis_tvalid && !output_m_axis_tready && stall_q != '1) begin
         stall_d = stall_q + 1'b1;
      end
      if (rst) stall_d = '0;
   end

   always_ff @(posedge clk) begin
      stall_q <= stall_d;
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

   assign byte_count      = byte_q;
   assign beat_count      = beat_q;
   assign tlast_count     = tlast_q;
   assign last_pkt_bytes  = last_q;
   assign max_pkt_bytes   = max_q;
   assign min_pkt_bytes   = min_q;
   assign hist_drop_count = drop_q;
   assign in_packet       = (state_q == S_IN_PKT);
   assign hist_empty      = empty;
   assign hist_full       = full;
   assign hist_rd_data    = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: doc/axis_stream_monitor.md
AXIS_STREAM_MONITOR -- requirements
Module: axis_stream_monitor

Interface
REQ-001 SHALL have parameter C_AXIS_BYTEWIDTH, default 4: stream width in bytes, 1..64.
REQ-002 SHALL have parameter C_COUNT_WIDTH, default 32: width of every count/length output, 16..64.
REQ-003 SHALL have parameter C_HIST_DEPTH, default 8: packet-length history FIFO depth, power of two, 2..256.
REQ-004 SHALL have ports, in this order:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- clear, input, 1, synchronous counter/FIFO clear pulse.
- input_s_axis_tvalid, input, 1, upstream valid.
- input_s_axis_tdata, input, C_AXIS_BYTEWIDTH*8, upstream data.
- input_s_axis_tstrb, input, C_AXIS_BYTEWIDTH, upstream byte strobes.
- input_s_axis_tlast, input, 1, upstream end of packet.
- input_s_axis_tready, output, 1, upstream ready.
- output_m_axis_tvalid, output_m_axis_tdata, output_m_axis_tstrb, output_m_axis_tlast, outputs, widths as inputs, downstream stream.
- output_m_axis_tready, input, 1, downstream ready.
- byte_count, beat_count, tlast_count, last_pkt_bytes, max_pkt_bytes, min_pkt_bytes, stall_count, hist_drop_count: outputs, C_COUNT_WIDTH each, statistics.
- in_packet, output, 1, packet state.
- hist_rd_en, input, 1, FIFO pop.
- hist_rd_data, output, C_COUNT_WIDTH, FIFO head.
- hist_empty, output, 1, FIFO empty flag.
- hist_full, output, 1, FIFO full flag.

Function
REQ-005 SHALL pass all stream signals through combinationally, zero latency: output tvalid/tdata/tstrb/tlast = inputs; input_s_axis_tready = output_m_axis_tready.
REQ-006 SHALL define beat = input_s_axis_tvalid AND output_m_axis_tready; all statistics SHALL update only on the clock edge following the beat's cycle.
REQ-007 SHALL add popcount(tstrb) to byte_count and 1 to beat_count per beat; both SHALL wrap modulo 2^C_COUNT_WIDTH.
REQ-008 SHALL keep an internal packet accumulator; non-tlast beat adds popcount(tstrb), saturating at all-ones.
REQ-009 On a tlast beat, len = accumulator + popcount(tstrb), saturating: tlast_count += 1 (wraps); last_pkt_bytes = len; max_pkt_bytes = max(max, len); min_pkt_bytes = min(min, len); accumulator = 0.
REQ-010 SHALL run a two-state FSM. IDLE -> IN_PKT on a non-tlast beat. IN_PKT -> IDLE on a tlast beat. in_packet = 1 in IN_PKT. A single-beat packet SHALL remain in IDLE.
REQ-011 SHALL push len into the history FIFO on each tlast beat.
- Full and no pop in the same cycle: entry SHALL be dropped and hist_drop_count incremented, saturating.
- Full with pop in the same cycle: push SHALL be accepted.
REQ-012 FIFO SHALL be first-word-fall-through: hist_rd_data shows the head whenever hist_empty = 0, and is 0 when empty. hist_rd_en pops one entry; hist_rd_en while empty SHALL be ignored.
REQ-013 Simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged. On an empty FIFO, the push lands and the pop is ignored.
REQ-014 clear SHALL have the same effect as reset on all state. A beat coinciding with clear SHALL NOT be counted.

Reset
REQ-015 While reset = 1, SHALL set: all counts, last_pkt_bytes, max_pkt_bytes, accumulator and hist_rd_data to 0; min_pkt_bytes to all-ones; FSM to IDLE; FIFO empty (hist_empty = 1, hist_full = 0).
REQ-016 The passthrough SHALL remain active during reset; reset mid-packet discards the partial length, and the next tlast packet length counts only beats after reset.

Configuration
REQ-017 With macro AXIS_MON_STALL_EN defined, stall_count SHALL increment, saturating, on each cycle with input_s_axis_tvalid = 1 and output_m_axis_tready = 0.
REQ-018 Without AXIS_MON_STALL_EN, stall_count SHALL be constant 0 and no stall counter logic SHALL be synthesised.

Verification
REQ-019 Bench SHALL cover, with defaults:
- 3 beats, tstrb = F,F,3, tlast on beat 3 -> byte_count = 10, beat_count = 3, tlast_count = 1, last/max/min_pkt_bytes = 10, hist_rd_data = 10.
- Packets of 4, 12 and 8 bytes -> max_pkt_bytes = 12, min_pkt_bytes = 4, FIFO pops return 4, 12, 8 in order, then hist_empty = 1.
- 10 single-beat tlast packets, no pops -> hist_full = 1, hist_drop_count = 2, first pop returns the first packet's length.
- tvalid = 1, tready = 0 for 5 cycles, then 1 beat -> beat_count = 1, stall_count = 5 with AXIS_MON_STALL_EN, 0 without.
- reset after 2 non-tlast beats (in_packet = 1), then 1 tlast beat with tstrb = F -> in_packet = 0, tlast_count = 1, last_pkt_bytes = 4.
- clear coincident with a beat -> all counts 0, hist_empty = 1 next cycle; the passthrough data is unchanged.
